// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Buffered parallel-to-serial stage. WIDTH-bit words are accepted over a
//   valid/ready handshake into a DEPTH-word circular FIFO, then shifted out
//   one bit per clock on dout (qualified by dout_valid). Consecutive words
//   stream with no idle gap. dout holds IDLE_BIT while no data bit is present.
//
// Ports
//   clk        : clock, rising edge
//   resetn     : synchronous, active-low reset
//   in_data    : word to serialize
//   in_valid   : in_data valid
//   in_ready   : FIFO can accept a word this cycle
//   dout       : serial bit
//   dout_valid : dout carries a data bit
//   level      : words held in the FIFO (excludes the word in the shifter)
//   busy       : dout_valid | (level != 0)
module serial_bit_feeder #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1,
   parameter int IDLE_BIT  = 0
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     dout,
   output logic                     dout_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(WIDTH);

   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic          IDLE_VAL = (IDLE_BIT != 0);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             dout_valid_q, dout_valid_d;

   logic push;
   logic pop;
   logic last_bit;

   assign in_ready = (count_q != FULL_LVL);
   assign push     = in_valid & in_ready;
   assign last_bit = (bit_cnt_q == LAST_BIT);
   // Reload on the edge that ends the last bit keeps back-to-back words gapless.
   assign pop      = (!dout_valid_q || last_bit) && (count_q != '0);

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      dout_valid_d = dout_valid_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (pop) begin
         shreg_d      = mem_q[rd_ptr_q];
         bit_cnt_d    = '0;
         dout_valid_d = 1'b1;
      end else if (dout_valid_q && !last_bit) begin
         if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
         else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
         bit_cnt_d = bit_cnt_q + BW'(1);
      end else if (dout_valid_q) begin
         // last bit done and nothing queued
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (resetn && push) mem_q[wr_ptr_q] <= in_data;
   end

   always_comb begin
      dout = IDLE_VAL;
      if (dout_valid_q) dout = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
   end

   assign dout_valid = dout_valid_q;
   assign level      = count_q;
   assign busy       = dout_valid_q | (count_q != '0);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder
//   Drives two serial_bit_feeder instances (MSB-first/idle 0 and
//   LSB-first/idle 1) from the same handshake inputs. Each accepted word is
//   pushed into a scoreboard as WIDTH entries carrying the cycle in which
//   the bit must appear; a negedge monitor pops and compares.
module tb_serial_bit_feeder;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk;
   logic         resetn;
   logic [W-1:0] in_data;
   logic         in_valid;

   logic                 rdy_m, dout_m, dv_m, busy_m;
   logic                 rdy_l, dout_l, dv_l, busy_l;
   logic [$clog2(D):0]   lvl_m, lvl_l;

   serial_bit_feeder #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1), .IDLE_BIT(0)) u_msb (
      .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .level(lvl_m), .busy(busy_m)
   );

   serial_bit_feeder #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0), .IDLE_BIT(1)) u_lsb (
      .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .level(lvl_l), .busy(busy_l)
   );

   typedef struct {
      logic [W-1:0] word;
      int           idx;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   starts[$];   // start cycles of accepted words not yet in the shifter
   int   cyc    = 0;
   int   last_s = -1000;
   bit   mon_en = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp_v);
      end
   endfunction

   // Reference: a word accepted at edge a starts at max(a+1, previous start + W)
   // and occupies W consecutive cycles; FIFO level is the count of accepted
   // words whose start lies in the future.
   task automatic step(input logic v, input logic [W-1:0] d, input logic rst, output logic acc);
      int s;
      in_valid = v;
      in_data  = d;
      resetn   = ~rst;
      acc      = !rst && v && (starts.size() != D);
      @(posedge clk);
      cyc++;
      if (rst) begin
         exp_q.delete();
         starts.delete();
         last_s = -1000;
         mon_en = 1;
      end else begin
         while (starts.size() > 0 && starts[0] <= cyc) void'(starts.pop_front());
         if (acc) begin
            s = (cyc + 1 > last_s + W) ? cyc + 1 : last_s + W;
            for (int i = 0; i < W; i++) exp_q.push_back('{word: d, idx: i, cyc: s + i});
            starts.push_back(s);
            last_s = s;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
   endtask

   task automatic push_hold(input logic [W-1:0] d);
      logic a;
      int   tries;
      a = 1'b0;
      tries = 0;
      while (!a && tries < 60) begin
         step(1'b1, d, 1'b0, a);
         tries++;
      end
      if (!a) chk("accept_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit   exp_v;
         int   lvl;
         exp_t e;
         exp_v = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
         lvl   = starts.size();
         chk("dout_valid_msb", int'(dv_m), int'(exp_v));
         chk("dout_valid_lsb", int'(dv_l), int'(exp_v));
         if (exp_v) begin
            e = exp_q.pop_front();
            chk("dout_msb", int'(dout_m), int'(e.word[W-1-e.idx]));
            chk("dout_lsb", int'(dout_l), int'(e.word[e.idx]));
         end else begin
            chk("idle_msb", int'(dout_m), 0);
            chk("idle_lsb", int'(dout_l), 1);
         end
         chk("level", int'(lvl_m), lvl);
         chk("level_lsb", int'(lvl_l), lvl);
         chk("in_ready", int'(rdy_m), int'(lvl != D));
         chk("busy", int'(busy_m), int'(exp_v || lvl != 0));
         chk("busy_lsb", int'(busy_l), int'(exp_v || lvl != 0));
      end
   end

   initial begin
      logic a;
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      step(1'b0, '0, 1'b1, a);
      step(1'b1, 8'h33, 1'b1, a);   // push during reset is discarded
      idle(3);

      // single word into idle block
      step(1'b1, 8'h0A, 1'b0, a);
      idle(12);

      // back-to-back words
      step(1'b1, 8'hA5, 1'b0, a);
      step(1'b1, 8'h5A, 1'b0, a);
      idle(20);

      // fill the FIFO with upstream holding each word until accepted
      for (int w = 1; w <= 6; w++) push_hold(W'(w));
      in_valid = 1'b0;
      idle(60);

      // reset while the 4th bit of 0xFF is on dout
      step(1'b1, 8'hFF, 1'b0, a);
      step(1'b1, 8'h0F, 1'b0, a);
      idle(3);
      step(1'b0, '0, 1'b1, a);
      idle(20);

      // randomized traffic with occasional resets
      for (int i = 0; i < 900; i++) begin
         logic v, r;
         v = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 249) == 0);
         step(v, W'($urandom), r, a);
      end
      idle(80);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
